// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next PC (sequential, branch, jump, trap, mret),
// runs the req/ack fetch handshake to instruction memory, and supports halt/resume.
//
// state | meaning
// BOOT  | one idle cycle after reset, no fetch request
// FETCH | normal operation, requests fetches and applies redirects
// HALT  | pc frozen, no request, redirects ignored until resume
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              INSTR_BYTES  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    input  logic            mret,
    input  logic            halt,
    input  logic            resume,
    input  logic            imem_ack,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] epc,
    output logic            flush,
    output logic            misaligned,
    output logic [31:0]     fetch_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] epc_next;
    logic            flush_next;
    logic            misaligned_next;
    logic [31:0]     count_next;

    logic            fetch_accepted;
    logic            target_valid;
    logic [XLEN-1:0] target;
    logic            target_bad;

    assign imem_req       = (state == FETCH) & ~stall;
    assign imem_addr      = pc;
    assign fetch_accepted = imem_req & imem_ack;

    // jump outranks branch, so the jump target is the one checked for alignment
    assign target_valid = jump | branch_taken;
    assign target       = jump ? jump_target : branch_target;
    assign target_bad   = target_valid & (target[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            epc         <= '0;
            flush       <= 1'b0;
            misaligned  <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            epc         <= epc_next;
            flush       <= flush_next;
            misaligned  <= misaligned_next;
            fetch_count <= count_next;
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        epc_next        = epc;
        flush_next      = 1'b0;
        misaligned_next = 1'b0;
        count_next      = fetch_count;

        case (state)
            BOOT: begin
                state_next = FETCH;
            end

            FETCH: begin
                if (halt) begin
                    state_next = HALT;
                end else if (trap) begin
                    pc_next    = TRAP_VECTOR;
                    epc_next   = pc;
                    flush_next = 1'b1;
                end else if (mret) begin
                    pc_next    = epc;
                    flush_next = 1'b1;
                end else if (target_bad) begin
                    pc_next         = TRAP_VECTOR;
                    epc_next        = pc;
                    flush_next      = 1'b1;
                    misaligned_next = 1'b1;
                end else if (target_valid) begin
                    pc_next    = target;
                    flush_next = 1'b1;
                end else if (fetch_accepted) begin
                    // any redirect above discards the acked instruction instead
                    pc_next    = pc + XLEN'(INSTR_BYTES);
                    count_next = fetch_count + 32'd1;
                end
            end

            HALT: begin
                if (resume) begin
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: one task per scenario, inline checks.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        trap;
    logic        mret;
    logic        halt;
    logic        resume;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        flush;
    logic        misaligned;
    logic [31:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .mret          (mret),
        .halt          (halt),
        .resume        (resume),
        .imem_ack      (imem_ack),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .epc           (epc),
        .flush         (flush),
        .misaligned    (misaligned),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        trap          = 1'b0;
        mret          = 1'b0;
        halt          = 1'b0;
        resume        = 1'b0;
        imem_ack      = 1'b0;
    endtask

    // reset, release, pass BOOT, then advance n accepted fetches
    task automatic reset_and_advance(input int n);
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        imem_ack = 1'b1;
        for (int i = 0; i < n; i++) tick();
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        imem_ack = 1'b1;
        reset = 1'b1;
        #3;
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        n_tests++; if (epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc got %h want %h", epc, 32'h0); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
        n_tests++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fetch_count); end
        n_tests++; if ({flush, misaligned} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got %b want 00", {flush, misaligned}); end
        tick();
        reset = 1'b0;
        #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req got %b want 0", imem_req); end
        tick();
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL boot_pc got %h want %h", pc, 32'h0); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req[%0d] got %b want 1", i, imem_req); end
            n_tests++; if (imem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_addr[%0d] got %h want %h", i, imem_addr, 32'(i * 4)); end
            tick();
        end
        n_tests++; if (fetch_count !== 32'd4) begin n_fail++; $display("FAIL seq_count got %0d want 4", fetch_count); end
        n_tests++; if (pc !== 32'h10) begin n_fail++; $display("FAIL seq_pc got %h want %h", pc, 32'h10); end
        clear_inputs();
    endtask

    task automatic test_branch();
        reset_and_advance(2);
        n_tests++; if (pc !== 32'h8) begin n_fail++; $display("FAIL br_start_pc got %h want %h", pc, 32'h8); end
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        imem_ack      = 1'b1;
        tick();
        clear_inputs();
        n_tests++; if (pc !== 32'h40) begin n_fail++; $display("FAIL br_pc got %h want %h", pc, 32'h40); end
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL br_flush got %b want 1", flush); end
        n_tests++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL br_count got %0d want 2", fetch_count); end
        n_tests++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL br_mis got %b want 0", misaligned); end
        tick();
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL br_flush_end got %b want 0", flush); end
        n_tests++; if (pc !== 32'h40) begin n_fail++; $display("FAIL br_hold_pc got %h want %h", pc, 32'h40); end
    endtask

    task automatic test_trap_mret();
        reset_and_advance(4);
        trap        = 1'b1;
        jump        = 1'b1;
        jump_target = 32'h80;
        tick();
        clear_inputs();
        n_tests++; if (pc !== 32'h100) begin n_fail++; $display("FAIL trap_pc got %h want %h", pc, 32'h100); end
        n_tests++; if (epc !== 32'h10) begin n_fail++; $display("FAIL trap_epc got %h want %h", epc, 32'h10); end
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL trap_flush got %b want 1", flush); end
        mret = 1'b1;
        tick();
        clear_inputs();
        n_tests++; if (pc !== 32'h10) begin n_fail++; $display("FAIL mret_pc got %h want %h", pc, 32'h10); end
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL mret_flush got %b want 1", flush); end
        jump        = 1'b1;
        jump_target = 32'h200;
        tick();
        clear_inputs();
        trap = 1'b1;
        mret = 1'b1;
        tick();
        clear_inputs();
        n_tests++; if (pc !== 32'h100) begin n_fail++; $display("FAIL trapmret_pc got %h want %h", pc, 32'h100); end
        n_tests++; if (epc !== 32'h200) begin n_fail++; $display("FAIL trapmret_epc got %h want %h", epc, 32'h200); end
    endtask

    task automatic test_misaligned();
        reset_and_advance(1);
        jump        = 1'b1;
        jump_target = 32'h22;
        imem_ack    = 1'b1;
        tick();
        clear_inputs();
        n_tests++; if (pc !== 32'h100) begin n_fail++; $display("FAIL mis_pc got %h want %h", pc, 32'h100); end
        n_tests++; if (epc !== 32'h4) begin n_fail++; $display("FAIL mis_epc got %h want %h", epc, 32'h4); end
        n_tests++; if ({misaligned, flush} !== 2'b11) begin n_fail++; $display("FAIL mis_pulses got %b want 11", {misaligned, flush}); end
        n_tests++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL mis_count got %0d want 1", fetch_count); end
        tick();
        n_tests++; if ({misaligned, flush} !== 2'b00) begin n_fail++; $display("FAIL mis_pulses_end got %b want 00", {misaligned, flush}); end
        branch_taken  = 1'b1;
        branch_target = 32'h41;
        tick();
        clear_inputs();
        n_tests++; if (pc !== 32'h100) begin n_fail++; $display("FAIL mis_br_pc got %h want %h", pc, 32'h100); end
        n_tests++; if (epc !== 32'h100) begin n_fail++; $display("FAIL mis_br_epc got %h want %h", epc, 32'h100); end
        n_tests++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_br_flag got %b want 1", misaligned); end
    endtask

    task automatic test_stall();
        reset_and_advance(8);
        stall    = 1'b1;
        imem_ack = 1'b1;
        #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req got %b want 0", imem_req); end
        for (int i = 0; i < 3; i++) tick();
        n_tests++; if (pc !== 32'h20) begin n_fail++; $display("FAIL stall_pc got %h want %h", pc, 32'h20); end
        n_tests++; if (fetch_count !== 32'd8) begin n_fail++; $display("FAIL stall_count got %0d want 8", fetch_count); end
        branch_taken  = 1'b1;
        branch_target = 32'h60;
        tick();
        clear_inputs();
        n_tests++; if (pc !== 32'h60) begin n_fail++; $display("FAIL stall_br_pc got %h want %h", pc, 32'h60); end
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL stall_br_flush got %b want 1", flush); end
    endtask

    task automatic test_wrap();
        reset_and_advance(0);
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h want %h", pc, 32'h0); end
        n_tests++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL wrap_count got %0d want 1", fetch_count); end
    endtask

    task automatic test_back_to_back();
        reset_and_advance(0);
        jump        = 1'b1;
        jump_target = 32'h300;
        tick();
        clear_inputs();
        branch_taken  = 1'b1;
        branch_target = 32'h400;
        tick();
        clear_inputs();
        n_tests++; if (pc !== 32'h400) begin n_fail++; $display("FAIL b2b_pc got %h want %h", pc, 32'h400); end
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL b2b_flush got %b want 1", flush); end
        jump          = 1'b1;
        jump_target   = 32'h500;
        branch_taken  = 1'b1;
        branch_target = 32'h600;
        tick();
        clear_inputs();
        n_tests++; if (pc !== 32'h500) begin n_fail++; $display("FAIL jmp_over_br_pc got %h want %h", pc, 32'h500); end
    endtask

    task automatic test_halt();
        reset_and_advance(12);
        n_tests++; if (pc !== 32'h30) begin n_fail++; $display("FAIL halt_start_pc got %h want %h", pc, 32'h30); end
        halt = 1'b1;
        tick();
        clear_inputs();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_req got %b want 0", imem_req); end
        trap        = 1'b1;
        jump        = 1'b1;
        jump_target = 32'h80;
        tick();
        clear_inputs();
        n_tests++; if (pc !== 32'h30) begin n_fail++; $display("FAIL halt_pc got %h want %h", pc, 32'h30); end
        n_tests++; if (epc !== 32'h0) begin n_fail++; $display("FAIL halt_epc got %h want %h", epc, 32'h0); end
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL halt_flush got %b want 0", flush); end
        resume = 1'b1;
        tick();
        clear_inputs();
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL resume_req got %b want 1", imem_req); end
        n_tests++; if (imem_addr !== 32'h30) begin n_fail++; $display("FAIL resume_addr got %h want %h", imem_addr, 32'h30); end
        halt = 1'b1;
        tick();
        clear_inputs();
        #2;
        reset = 1'b1;
        #1;
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL async_rst_pc got %h want %h", pc, 32'h0); end
        n_tests++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL async_rst_count got %0d want 0", fetch_count); end
        tick();
        reset = 1'b0;
        resume = 1'b1;
        #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_boot_req got %b want 0", imem_req); end
        tick();
        clear_inputs();
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_req got %b want 1", imem_req); end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_branch();
        test_trap_mret();
        test_misaligned();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
